router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx_if.sv | 35 +++
 rtl/router_pkt_tx.sv | 162 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Packet-source bus between the local requester and router_pkt_tx.
// ROUTER_PKT_TX_CORRUPT_EN adds the corrupt_parity request bit.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       packet_valid;
  logic       tx_active;
  logic       done;
  logic       req_err;
`ifdef ROUTER_PKT_TX_CORRUPT_EN
  logic       corrupt_parity;
`endif

  modport master (
`ifdef ROUTER_PKT_TX_CORRUPT_EN
    output corrupt_parity,
`endif
    output start, dest_addr, payload_len, pay_data, pay_valid, busy,
    input  pay_ready, data_out, packet_valid, tx_active, done, req_err
  );

  modport slave (
`ifdef ROUTER_PKT_TX_CORRUPT_EN
    input  corrupt_parity,
`endif
    input  start, dest_addr, payload_len, pay_data, pay_valid, busy,
    output pay_ready, data_out, packet_valid, tx_active, done, req_err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers one payload, then sends header, payload and XOR parity to the router.
// ROUTER_PKT_TX_CORRUPT_EN enables latched parity inversion for error injection.
module router_pkt_tx (
  input  logic           clk,
  input  logic           reset,
  router_pkt_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  state_t     state_reg;
  logic [5:0] len_reg;
  logic [1:0] addr_reg;
  logic [5:0] count_reg;
  logic [5:0] idx_reg;
  logic [7:0] parity_reg;
  logic [7:0] data_out_reg;
  logic       packet_valid_reg;
  logic       pay_ready_reg;
  logic       tx_active_reg;
  logic       done_reg;
  logic       req_err_reg;

  logic [7:0] buffer_mem [0:62];
  logic [7:0] rd_data_reg;
  logic [6:0] rd_addr_next;
  logic [5:0] rd_addr;
  logic       wr_en;
  logic [7:0] header;
  logic [7:0] parity_out;

  assign header = {len_reg, addr_reg};
  assign wr_en  = (state_reg == S_LOAD) && bus.pay_valid && pay_ready_reg;

`ifdef ROUTER_PKT_TX_CORRUPT_EN
  logic corrupt_reg;
  assign parity_out = corrupt_reg ? ~parity_reg : parity_reg;
`else
  assign parity_out = parity_reg;
`endif

  // Read one entry ahead of the bus so the next payload byte is waiting in
  // rd_data_reg when the current one is released.
  always_comb begin
    rd_addr_next = 7'd0;
    case (state_reg)
      S_HEADER:  rd_addr_next = bus.busy ? 7'd0 : 7'd1;
      S_PAYLOAD: rd_addr_next = {1'b0, idx_reg} + (bus.busy ? 7'd1 : 7'd2);
      default:   rd_addr_next = 7'd0;
    endcase
    rd_addr = (rd_addr_next > 7'd62) ? 6'd0 : rd_addr_next[5:0];
  end

  // Write-through bypass covers len=1, where entry 0 is written on the same
  // edge it must be read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer_mem[count_reg] <= bus.pay_data;
    end
    if (wr_en && (count_reg == rd_addr)) begin
      rd_data_reg <= bus.pay_data;
    end else begin
      rd_data_reg <= buffer_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      len_reg          <= 6'd0;
      addr_reg         <= 2'd0;
      count_reg        <= 6'd0;
      idx_reg          <= 6'd0;
      parity_reg       <= 8'd0;
      data_out_reg     <= 8'd0;
      packet_valid_reg <= 1'b0;
      pay_ready_reg    <= 1'b0;
      tx_active_reg    <= 1'b0;
      done_reg         <= 1'b0;
      req_err_reg      <= 1'b0;
`ifdef ROUTER_PKT_TX_CORRUPT_EN
      corrupt_reg      <= 1'b0;
`endif
    end else begin
      done_reg    <= 1'b0;
      req_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            if ((bus.payload_len != 6'd0) && (bus.dest_addr != 2'd3)) begin
              len_reg       <= bus.payload_len;
              addr_reg      <= bus.dest_addr;
              count_reg     <= 6'd0;
              idx_reg       <= 6'd0;
              parity_reg    <= {bus.payload_len, bus.dest_addr};
              pay_ready_reg <= 1'b1;
              tx_active_reg <= 1'b1;
`ifdef ROUTER_PKT_TX_CORRUPT_EN
              corrupt_reg   <= bus.corrupt_parity;
`endif
              state_reg     <= S_LOAD;
            end else begin
              req_err_reg <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (wr_en) begin
            count_reg  <= count_reg + 6'd1;
            parity_reg <= parity_reg ^ bus.pay_data;
            if (count_reg == (len_reg - 6'd1)) begin
              pay_ready_reg    <= 1'b0;
              data_out_reg     <= header;
              packet_valid_reg <= 1'b1;
              state_reg        <= S_HEADER;
            end
          end
        end
        S_HEADER: begin
          if (!bus.busy) begin
            data_out_reg <= rd_data_reg;
            idx_reg      <= 6'd0;
            state_reg    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!bus.busy) begin
            if (idx_reg == (len_reg - 6'd1)) begin
              data_out_reg     <= parity_out;
              packet_valid_reg <= 1'b0;
              state_reg        <= S_PARITY;
            end else begin
              data_out_reg <= rd_data_reg;
              idx_reg      <= idx_reg + 6'd1;
            end
          end
        end
        S_PARITY: begin
          data_out_reg     <= 8'd0;
          packet_valid_reg <= 1'b0;
          done_reg         <= 1'b1;
          state_reg        <= S_GAP;
        end
        S_GAP: begin
          tx_active_reg <= 1'b0;
          state_reg     <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out     = data_out_reg;
  assign bus.packet_valid = packet_valid_reg;
  assign bus.pay_ready    = pay_ready_reg;
  assign bus.tx_active    = tx_active_reg;
  assign bus.done         = done_reg;
  assign bus.req_err      = req_err_reg;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: basic, stalled, illegal, max-length,
// reset-abort and (with ROUTER_PKT_TX_CORRUPT_EN) corrupted-parity packets.
module tb_router_pkt_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  router_pkt_tx_if bus ();

  router_pkt_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pay_buf  [0:63];
  logic [7:0] obs_data [0:127];
  logic       obs_pv   [0:127];
  logic       obs_done [0:127];
  int         n_obs;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a packet and feed its payload; returns with the header on the bus.
  task automatic load_pkt(input logic [1:0] addr, input logic [5:0] len,
                          input logic corrupt, input logic gap_once);
    bus.start = 1'b1;
    bus.dest_addr = addr;
    bus.payload_len = len;
`ifdef ROUTER_PKT_TX_CORRUPT_EN
    bus.corrupt_parity = corrupt;
`else
    if (corrupt) $display("corrupt request ignored in this build");
`endif
    tick();
    bus.start = 1'b0;
    check_val("load_ready", {15'd0, bus.pay_ready}, 16'd1);
    check_val("load_active", {15'd0, bus.tx_active}, 16'd1);
    for (int i = 0; i < int'(len); i++) begin
      if (gap_once && i == 1) begin
        bus.pay_valid = 1'b0;
        bus.start = 1'b1;
        bus.payload_len = 6'd0;
        tick();
        check_val("start_ignored", {15'd0, bus.req_err}, 16'd0);
        bus.start = 1'b0;
      end
      bus.pay_data = pay_buf[i];
      bus.pay_valid = 1'b1;
      tick();
    end
    bus.pay_valid = 1'b0;
  endtask

  // Record the bus every cycle until done, stalling for stall_len edges from stall_at.
  task automatic run_bus(input int stall_at, input int stall_len);
    int c;
    c = 0;
    obs_data[0] = bus.data_out;
    obs_pv[0] = bus.packet_valid;
    obs_done[0] = bus.done;
    while (!bus.done && c < 120) begin
      bus.busy = (c >= stall_at) && (c < stall_at + stall_len);
      tick();
      c++;
      obs_data[c] = bus.data_out;
      obs_pv[c] = bus.packet_valid;
      obs_done[c] = bus.done;
    end
    bus.busy = 1'b0;
    n_obs = c + 1;
    if (!bus.done) check_val("bus_timeout", 16'd0, 16'd1);
    $display("packet observed over %0d cycles, last byte 0x%0h", n_obs, bus.data_out);
  endtask

  task automatic basic_pkt(input string tag, input logic corrupt, input logic [7:0] par,
                           input logic gap_once);
    logic [7:0] exp_d [0:5];
    logic       exp_pv [0:5];
    exp_d  = '{8'h0D, 8'h11, 8'h22, 8'h33, par, 8'h00};
    exp_pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
    load_pkt(2'd1, 6'd3, corrupt, gap_once);
    run_bus(1000, 0);
    check_val({tag, "_len"}, n_obs[15:0], 16'd6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("%s_d%0d", tag, i), {8'd0, obs_data[i]}, {8'd0, exp_d[i]});
      check_val($sformatf("%s_pv%0d", tag, i), {15'd0, obs_pv[i]}, {15'd0, exp_pv[i]});
    end
    check_val({tag, "_done_early"}, {15'd0, obs_done[4]}, 16'd0);
    tick();
    check_val({tag, "_done_once"}, {15'd0, bus.done}, 16'd0);
    check_val({tag, "_idle"}, {15'd0, bus.tx_active}, 16'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.dest_addr = 2'd0; bus.payload_len = 6'd0;
    bus.pay_data = 8'd0; bus.pay_valid = 1'b0; bus.busy = 1'b0;
`ifdef ROUTER_PKT_TX_CORRUPT_EN
    bus.corrupt_parity = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    check_val("rst_data", {8'd0, bus.data_out}, 16'd0);
    check_val("rst_pv", {15'd0, bus.packet_valid}, 16'd0);
    check_val("rst_ready", {15'd0, bus.pay_ready}, 16'd0);
    check_val("rst_active", {15'd0, bus.tx_active}, 16'd0);
    check_val("rst_done", {15'd0, bus.done}, 16'd0);
    check_val("rst_err", {15'd0, bus.req_err}, 16'd0);

    basic_pkt("basic", 1'b0, 8'h0D, 1'b1);

    // Four busy edges while 0x22 is shown: it stays up for five cycles.
    begin
      logic [7:0] exp_d [0:9];
      logic       exp_pv [0:9];
      exp_d  = '{8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h0D, 8'h00};
      exp_pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      load_pkt(2'd1, 6'd3, 1'b0, 1'b0);
      run_bus(2, 4);
      check_val("stall_len", n_obs[15:0], 16'd10);
      for (int i = 0; i < 10; i++) begin
        check_val($sformatf("stall_d%0d", i), {8'd0, obs_data[i]}, {8'd0, exp_d[i]});
        check_val($sformatf("stall_pv%0d", i), {15'd0, obs_pv[i]}, {15'd0, exp_pv[i]});
      end
      tick();
    end

    // Illegal requests: len=0, then addr=3.
    for (int k = 0; k < 2; k++) begin
      bus.start = 1'b1;
      bus.payload_len = (k == 0) ? 6'd0 : 6'd5;
      bus.dest_addr = (k == 0) ? 2'd1 : 2'd3;
      tick();
      bus.start = 1'b0;
      check_val($sformatf("ill%0d_err", k), {15'd0, bus.req_err}, 16'd1);
      check_val($sformatf("ill%0d_active", k), {15'd0, bus.tx_active}, 16'd0);
      check_val($sformatf("ill%0d_pv", k), {15'd0, bus.packet_valid}, 16'd0);
      tick();
      check_val($sformatf("ill%0d_err_pulse", k), {15'd0, bus.req_err}, 16'd0);
      check_val($sformatf("ill%0d_active2", k), {15'd0, bus.tx_active}, 16'd0);
    end

    // Max length: header 0xFC, parity 0xFC ^ (0x00^..^0x3E) = 0xFC ^ 0x3F = 0xC3.
    for (int i = 0; i < 63; i++) pay_buf[i] = 8'(i);
    load_pkt(2'd0, 6'd63, 1'b0, 1'b0);
    run_bus(1000, 0);
    check_val("max_len", n_obs[15:0], 16'd66);
    check_val("max_hdr", {8'd0, obs_data[0]}, 16'h00FC);
    for (int i = 1; i <= 63; i++) begin
      check_val($sformatf("max_d%0d", i), {8'd0, obs_data[i]}, 16'(i - 1));
      check_val($sformatf("max_pv%0d", i), {15'd0, obs_pv[i]}, 16'd1);
    end
    check_val("max_par", {8'd0, obs_data[64]}, 16'h00C3);
    check_val("max_par_pv", {15'd0, obs_pv[64]}, 16'd0);
    check_val("max_gap", {8'd0, obs_data[65]}, 16'd0);
    tick();

    // Reset while payload index 2 (0xA2) is on the bus.
    for (int i = 0; i < 5; i++) pay_buf[i] = 8'hA0 + 8'(i);
    load_pkt(2'd2, 6'd5, 1'b0, 1'b0);
    check_val("abort_hdr", {8'd0, bus.data_out}, 16'h0016);
    tick(); tick(); tick();
    check_val("abort_idx2", {8'd0, bus.data_out}, 16'h00A2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_pv", {15'd0, bus.packet_valid}, 16'd0);
    check_val("abort_active", {15'd0, bus.tx_active}, 16'd0);
    check_val("abort_data", {8'd0, bus.data_out}, 16'd0);
    tick();
    check_val("abort_no_parity", {8'd0, bus.data_out}, 16'd0);
    basic_pkt("restart", 1'b0, 8'h0D, 1'b0);

`ifdef ROUTER_PKT_TX_CORRUPT_EN
    basic_pkt("corrupt", 1'b1, 8'hF2, 1'b0);
    basic_pkt("uncorrupt", 1'b0, 8'h0D, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
